word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial front end for the serial residue checkers (divisible-by-N FSMs). It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per accepted serial beat. Frame markers tell the downstream checker where each word starts, so it can clear its residue, and where it ends, so it can sample its result.

## Interface
- WIDTH, default 8: word width in bits, WIDTH ≥ 2.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- in_data  in  WIDTH  word to serialize, unsigned, MSB transmitted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted on the edge where in_valid && in_ready.
- ser_bit  out  1  current serial bit.
- ser_valid  out  1  ser_bit valid.
- ser_sof  out  1  ser_bit is bit WIDTH-1 of a word (first bit).
- ser_eof  out  1  ser_bit is bit 0 of a word (last bit).
- ser_ready  in  1  downstream consumes the bit on the edge where ser_valid && ser_ready.

## Operation
- FSM states: IDLE and SHIFT. Datapath: shift register sh[WIDTH-1:0] and bit counter cnt[$clog2(WIDTH)-1:0].
- Outputs are registered from sh and cnt:
  - ser_bit = sh[WIDTH-1]
  - ser_valid = (state == SHIFT)
  - ser_sof = ser_valid && cnt == 0
  - ser_eof = ser_valid && cnt == WIDTH-1
- IDLE:
  - On an input handshake: sh ← in_data, cnt ← 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, on a serial beat with cnt < WIDTH-1: sh ← sh << 1 (zero fill), cnt ← cnt+1.
- SHIFT, on a serial beat with cnt == WIDTH-1 (last bit):
  - If a next word is available: load it, cnt ← 0, stay in SHIFT (back-to-back, no gap).
  - Otherwise go to IDLE; sh and cnt return to 0.
- No serial beat: sh, cnt and all ser_* outputs hold. Bits never change while ser_valid && !ser_ready.
- in_ready without the skid buffer is combinational: (state == IDLE) || (ser_eof && ser_ready). This creates a combinational path ser_ready → in_ready.
- ser_bit = 0 whenever ser_valid = 0.
- Words are never dropped, duplicated or reordered. Bit order per word is in_data[WIDTH-1] down to in_data[0].

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE, sh = 0, cnt = 0.
  - ser_bit = 0, ser_valid = 0, ser_sof = 0, ser_eof = 0.
  - in_ready = 0 while rst is low. Skid buffer, when present, is empty.
- First cycle after rst deasserts: in_ready = 1.
- Latency: word accepted at edge k → ser_valid = 1 with ser_sof = 1 from the cycle after edge k.
- Throughput: with ser_ready tied high and in_valid held, one word per WIDTH cycles, with ser_valid continuously 1.
- Reset mid-word: the partial word is discarded. No ser_eof is produced for it. The stream restarts cleanly with ser_sof on the next accepted word.
- Simultaneous input handshake and last-bit beat: the new word's MSB appears on the following cycle.

## Configuration
- SER_SKID_EN defined: adds a one-word skid buffer.
  - in_ready = !buf_full, registered, which removes the ser_ready → in_ready path.
  - An accepted word loads the shifter directly if the shifter is in IDLE or completing its last bit that cycle; otherwise it goes into the buffer.
  - The buffer drains into the shifter on the last-bit beat.
  - A second word can therefore be accepted while the first is still shifting.
- SER_SKID_EN undefined: no buffer; in_ready is as given in Operation.

## Structure
- Package ser_pkg: state enum ser_state_t {IDLE, SHIFT}; default width constant SER_WIDTH_DEFAULT = 8.
- Sub-module ser_skid_buf (one-entry data+full register), instantiated only under SER_SKID_EN. All other logic stays in word_serializer.

## Test plan
- WIDTH=8, in_data=8'h0A, ser_ready=1 → ser_bit 0,0,0,0,1,0,1,0 over 8 cycles; sof on beat 1, eof on beat 8. A downstream divisible-by-5 checker cleared on sof reports divisible at eof.
- Back-to-back 8'hA5 then 8'h3C, in_valid held, ser_ready=1 → 16 consecutive ser_valid cycles with bits 10100101 00111100; second sof immediately follows first eof.
- 8'hF0 with ser_ready low on beats 3–5 → ser_bit stays at 1 and cnt stays at 2 for those cycles; word completes 3 cycles late and is intact.
- rst pulsed low after beat 4 of 8'hFF → all outputs 0 immediately; next word 8'h81 emits 10000001 with a fresh sof.
- SER_SKID_EN: send 8'h11, 8'h22, 8'h33 → 8'h22 accepted during 8'h11 shifting; in_ready falls; 8'h33 waits until the 8'h11 eof beat; stream is 11,22,33 with no gaps.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared types and constants for the word serializer.
//   ser_state_t       : serializer FSM state (IDLE, SHIFT)
//   SER_WIDTH_DEFAULT : default word width in bits
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/ser_skid_buf.sv
// ser_skid_buf: one-entry word holding register used to accept a word
// while the shifter is still busy with the previous one.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset (clears full)
//   load      in   capture load_data, mark full
//   load_data in   word to capture
//   drain     in   entry consumed by the shifter, mark empty
//   data      out  stored word
//   full      out  entry holds a word
module ser_skid_buf
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // load and drain are mutually exclusive: a full buffer deasserts
    // in_ready, so no new word can arrive in the cycle it drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // The payload is qualified by full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial front end for serial residue
// checkers. Accepts WIDTH-bit words over valid/ready and emits them
// MSB first, one bit per serial beat, with first/last-bit markers.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   in_data   in   word to serialize (MSB sent first)
//   in_valid  in   in_data valid
//   in_ready  out  word accepted when in_valid && in_ready
//   ser_bit   out  current serial bit (0 when ser_valid is low)
//   ser_valid out  ser_bit valid
//   ser_sof   out  ser_bit is the first bit of a word
//   ser_eof   out  ser_bit is the last bit of a word
//   ser_ready in   bit consumed when ser_valid && ser_ready
// Build option: define SER_SKID_EN to add a one-word skid buffer, which
// registers in_ready and removes the ser_ready -> in_ready path.
module word_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_sof,
    output logic             ser_eof,
    input  logic             ser_ready
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;

    logic             beat;
    logic             last_beat;
    logic             in_hs;
    logic             load_word;
    logic [WIDTH-1:0] load_data;

    assign beat      = (state == SHIFT) && ser_ready;
    assign last_beat = beat && (cnt == CNT_LAST);
    assign in_hs     = in_valid && in_ready;

`ifdef SER_SKID_EN
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;
    logic             direct;
    logic             buf_load;
    logic             buf_drain;

    // A word goes straight to the shifter when the shifter is free this
    // cycle; otherwise it parks in the buffer until the last-bit beat.
    assign direct    = (state == IDLE) || last_beat;
    assign buf_load  = in_hs && !direct;
    assign buf_drain = last_beat && buf_full;
    assign load_word = buf_drain || (in_hs && direct);
    // A buffered word is always older than anything on in_data.
    assign load_data = buf_full ? buf_data : in_data;

    ser_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .load_data(in_data),
        .drain    (buf_drain),
        .data     (buf_data),
        .full     (buf_full)
    );
`else
    assign load_word = in_hs;
    assign load_data = in_data;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_word) state_nxt = SHIFT;
            SHIFT:   if (last_beat && !load_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and bit counter; both hold when no beat occurs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load_word) begin
            sh  <= load_data;
            cnt <= '0;
        end else if (last_beat) begin
            sh  <= '0;
            cnt <= '0;
        end else if (beat) begin
            sh  <= {sh[WIDTH-2:0], 1'b0};
            cnt <= cnt + 1'b1;
        end
    end

    // Outputs
    always_comb begin
        ser_valid = (state == SHIFT);
        ser_bit   = ser_valid && sh[WIDTH-1];
        ser_sof   = ser_valid && (cnt == '0);
        ser_eof   = ser_valid && (cnt == CNT_LAST);
`ifdef SER_SKID_EN
        in_ready  = rst && !buf_full;
`else
        in_ready  = rst && ((state == IDLE) || last_beat);
`endif
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: self-checking bench for word_serializer (WIDTH=8).
// Accepted words are expanded into expected {bit, sof, eof} beats on a
// scoreboard queue; a monitor pops and compares on every serial beat and
// runs a divisible-by-5 residue checker over the stream.
module tb_word_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
    } beat_t;

    typedef struct {
        logic [W-1:0] data;
        bit           div5;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_bit;
    logic         ser_valid;
    logic         ser_sof;
    logic         ser_eof;
    logic         ser_ready;

    int    n_cmp;
    int    n_bad;
    beat_t exp_q[$];
    bit    div_q[$];
    bit    drv_div;
    int    residue;
    bit    held_v;
    beat_t held;
    int    run;
    int    max_run;

    word_serializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_bit  (ser_bit),
        .ser_valid(ser_valid),
        .ser_sof  (ser_sof),
        .ser_eof  (ser_eof),
        .ser_ready(ser_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. the values that the next
    // rising edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            div_q.delete();
            residue = 0;
            held_v  = 1'b0;
            run     = 0;
        end else begin
            if (!ser_valid)
                chk(!ser_bit && !ser_sof && !ser_eof, "idle_outputs_zero",
                    {ser_bit, ser_sof, ser_eof}, 0);
            if (held_v)
                chk(ser_valid && ({ser_bit, ser_sof, ser_eof} == held), "stall_hold",
                    {ser_valid, ser_bit, ser_sof, ser_eof}, {1'b1, held});
            held_v = ser_valid && !ser_ready;
            held   = '{b: ser_bit, sof: ser_sof, eof: ser_eof};

            if (ser_valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end

            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk({ser_bit, ser_sof, ser_eof} == e, "beat_bit_sof_eof",
                        {ser_bit, ser_sof, ser_eof}, e);
                end
                residue = ((ser_sof ? 0 : residue) * 2 + int'(ser_bit)) % 5;
                if (ser_eof) begin
                    if (div_q.size() == 0) begin
                        chk(1'b0, "unexpected_eof", 1, 0);
                    end else begin
                        bit d;
                        d = div_q.pop_front();
                        chk((residue == 0) == d, "div5_at_eof", int'(residue == 0), int'(d));
                    end
                end
            end

            if (in_valid && in_ready) begin
                for (int i = W - 1; i >= 0; i--)
                    exp_q.push_back('{b: in_data[i], sof: (i == W - 1), eof: (i == 0)});
                div_q.push_back(drv_div);
            end
        end
    end

    // Drive a word and hold it until the handshake edge has passed.
    task automatic send_word(input logic [W-1:0] d, input bit div);
        int n;
        in_data  = d;
        drv_div  = div;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(1'b0, "in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || ser_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk(1'b0, "drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        n_cmp = 0; n_bad = 0; residue = 0; held_v = 0; run = 0; max_run = 0;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; ser_ready = 1'b1; drv_div = 1'b0;

        vecs[0] = '{8'h0A, 1'b1};
        vecs[1] = '{8'h00, 1'b1};
        vecs[2] = '{8'h07, 1'b0};
        vecs[3] = '{8'h64, 1'b1};
        vecs[4] = '{8'hFF, 1'b1};
        vecs[5] = '{8'h81, 1'b0};
        vecs[6] = '{8'h96, 1'b1};
        vecs[7] = '{8'h01, 1'b0};
        vecs[8] = '{8'h80, 1'b0};
        vecs[9] = '{8'h7F, 1'b0};

        // Reset state
        #2;
        chk({in_ready, ser_valid, ser_bit, ser_sof, ser_eof} == 5'b0, "reset_outputs",
            {in_ready, ser_valid, ser_bit, ser_sof, ser_eof}, 0);
        #15 rst = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "ready_after_reset", in_ready, 1);
        chk(ser_valid == 1'b0, "valid_after_reset", ser_valid, 0);
        @(posedge clk);
        #1;

        // Table: single words, idle between, with first-bit latency check
        for (int i = 0; i < 10; i++) begin
            send_word(vecs[i].data, vecs[i].div5);
            @(negedge clk);
            chk(ser_valid && ser_sof, "first_bit_latency", {ser_valid, ser_sof}, 3);
            wait_drain();
        end

        // Back-to-back A5, 3C with in_valid held: 16 contiguous valid cycles
        max_run = 0;
        send_word(8'hA5, 1'b1);
        send_word(8'h3C, 1'b1);
        wait_drain();
        chk(max_run == 16, "back_to_back_run", max_run, 16);

        // F0 with ser_ready low on beats 3..5
        send_word(8'hF0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ser_ready = 1'b0;
        @(negedge clk);
        chk(ser_valid && ser_bit && !ser_sof && !ser_eof, "stall_bit_value",
            {ser_valid, ser_bit, ser_sof, ser_eof}, 4'b1100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ser_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(ser_valid && ser_eof, "stall_eof_delayed", {ser_valid, ser_eof}, 3);
        wait_drain();

        // Reset after beat 4 of FF, then a clean 81
        send_word(8'hFF, 1'b1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk({ser_valid, ser_bit, ser_sof, ser_eof, in_ready} == 5'b0, "midword_reset_outputs",
            {ser_valid, ser_bit, ser_sof, ser_eof, in_ready}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "ready_after_midword_reset", in_ready, 1);
        @(posedge clk); #1;
        send_word(8'h81, 1'b0);
        @(negedge clk);
        chk(ser_valid && ser_sof, "fresh_sof_after_reset", {ser_valid, ser_sof}, 3);
        wait_drain();

        // 11, 22, 33 streamed without gaps
        max_run = 0;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
`ifdef SER_SKID_EN
        chk(ser_valid && !ser_eof, "skid_second_word_early", {ser_valid, ser_eof}, 2);
        @(negedge clk);
        chk(in_ready == 1'b0, "skid_ready_falls", in_ready, 0);
`endif
        send_word(8'h33, 1'b0);
        wait_drain();
        chk(max_run == 24, "three_word_run", max_run, 24);
        chk(exp_q.size() == 0 && div_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1);
    end

endmodule
